// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction-fetch front end.
//   XLEN             : architectural register / address width
//   INSTR_BYTES      : fetch stride between sequential instruction words
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP              : canonical addi x0,x0,0 encoding
//   fetch_state_e    : fetch sequencer state encoding
//   word_align()     : clears the byte-offset bits of an address
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO with a show-ahead head.
//   clk, rst   : clock, asynchronous active-low reset
//   flush      : empties the FIFO at the clock edge (wins over push/pop)
//   push       : write push_data; caller guarantees space is available
//   push_data  : WIDTH-bit entry
//   pop        : drop the head entry (ignored when empty)
//   head_data  : current head, forced to zero while empty
//   count      : number of valid entries, 0..DEPTH
module prefetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;

  // Zero head while empty keeps the downstream data bus quiet in reset.
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Upstream credit accounting must make this unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !flush && full && !pop));

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: sequential fetch address generation, in-order
// memory request/response tracking, prefetch buffering and redirect flush.
//   clk, rst                    : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr   : fetch request port (word-aligned address)
//   imem_rsp_valid/data         : in-order, non-stallable memory responses
//   instr_valid/ready/data/pc   : instruction stream to the decoder
//   redirect_valid/pc           : flush and restart fetch at redirect_pc
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_BOOT | first cycle out of reset, no requests issued
// ST_RUN  | normal fetch; requests limited by FIFO + in-flight credit
module ifetch_prefetch
  import riscv_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [XLEN-1:0]  imem_rsp_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [XLEN-1:0]  instr_data,
  output logic [XLEN-1:0]  instr_pc,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state;
  logic [XLEN-1:0]   fetch_pc;
  // inflight: every request still owed a response (stale ones included).
  // discard : how many of those outstanding responses must be dropped.
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     aq_count;
  logic [CW:0]       credit_used;
  logic [XLEN-1:0]   aq_head;
  logic [2*XLEN-1:0] fifo_head;
  logic              req_fire;
  logic              rsp_keep;
  logic              instr_pop;

  assign credit_used    = {1'b0, fifo_count} + {1'b0, inflight};
  assign imem_req_valid = (state == ST_RUN) && !redirect_valid &&
                          (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response landing in the redirect cycle belongs to the old stream.
  assign rsp_keep  = imem_rsp_valid && !redirect_valid && (discard == '0);

  assign instr_valid = (fifo_count != '0);
  assign instr_pop   = instr_valid && instr_ready;
  assign instr_data  = fifo_head[2*XLEN-1:XLEN];
  assign instr_pc    = fifo_head[XLEN-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_BOOT;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_BOOT;
      endcase

      if (redirect_valid) begin
        fetch_pc <= word_align(redirect_pc);
        inflight <= inflight - CW'(imem_rsp_valid);
        // inflight already covers earlier stale requests, so everything still
        // outstanding after this cycle's response becomes discard.
        discard  <= inflight - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + INSTR_BYTES;
        inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
        if (imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  // Address queue: pcs of live (non-discarded) outstanding requests.
  prefetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .head_data (aq_head),
    .count     (aq_count)
  );

  prefetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({imem_rsp_data, aq_head}),
    .pop       (instr_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  a_aq_tracks_live: assert property (@(posedge clk) disable iff (!rst)
    aq_count <= inflight);
  a_discard_bound: assert property (@(posedge clk) disable iff (!rst)
    discard <= inflight);

endmodule

// File: tb/tb_ifetch_prefetch.sv
module tb_ifetch_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] SIG      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        instr_valid;
  logic        instr_ready    = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;

  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory environment: in-order responses, data = addr ^ SIG.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_pc;
    int          due;
  } mem_t;
  mem_t mem_q[$];

  // Reference model: expected stream of pcs waiting for delivery.
  logic [31:0] fifo_m[$];
  logic [31:0] fetch_m;
  int          stale_m;
  bit          run_m;

  logic [31:0] req_log[$];
  logic [31:0] deliv_log[$];
  int          cyc = 0;
  int          last_due = -1;
  int          lat_min = 1;
  int          lat_max = 1;
  int          n_deliv = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_instr_valid;
  logic [31:0] s_instr_pc;
  logic [31:0] s_instr_data;

  typedef struct {
    bit          rdy;
    bit          exp_rv;
    logic [31:0] exp_addr;
    bit          exp_iv;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    mem_q.delete();
    fifo_m.delete();
    req_log.delete();
    deliv_log.delete();
    fetch_m = RESET_PC;
    stale_m = 0;
    run_m = 1'b0;
    last_due = -1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit rdr, input logic [31:0] rpc, input bit rdy, input bit mrdy);
    bit          rsp;
    bit          exp_req;
    bit          pop;
    bit          fire;
    int          lat;
    mem_t        head;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    imem_req_ready = mrdy;
    rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    head = rsp ? mem_q[0] : '{32'h0, 32'h0, 0};
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? (head.addr ^ SIG) : 32'h0;
    #1;
    s_req_valid   = imem_req_valid;
    s_req_addr    = imem_req_addr;
    s_instr_valid = instr_valid;
    s_instr_pc    = instr_pc;
    s_instr_data  = instr_data;

    exp_req = run_m && !rdr && ((fifo_m.size() + mem_q.size()) < DEPTH);
    check("req_valid", 32'(s_req_valid), 32'(exp_req));
    if (exp_req && s_req_valid) check("req_addr", s_req_addr, fetch_m);
    check("instr_valid", 32'(s_instr_valid), 32'(fifo_m.size() != 0));
    if (s_instr_valid && fifo_m.size() != 0) begin
      check("instr_pc", s_instr_pc, fifo_m[0]);
      check("instr_data", s_instr_data, fifo_m[0] ^ SIG);
    end

    pop  = s_instr_valid && rdy;
    fire = s_req_valid && mrdy;
    if (pop && fifo_m.size() != 0) begin
      deliv_log.push_back(fifo_m.pop_front());
      n_deliv++;
    end
    if (rsp) begin
      void'(mem_q.pop_front());
      if (!rdr) begin
        if (stale_m > 0) stale_m--;
        else fifo_m.push_back(head.exp_pc);
      end
    end
    if (fire) begin
      lat = int'($urandom_range(lat_max, lat_min));
      last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mem_q.push_back('{s_req_addr, fetch_m, last_due});
      req_log.push_back(s_req_addr);
      fetch_m = fetch_m + 32'd4;
    end
    if (rdr) begin
      fetch_m = {rpc[31:2], 2'b00};
      fifo_m.delete();
      stale_m = mem_q.size();
    end
    run_m = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    bit          r_rdr;
    bit          r_rdy;
    bit          r_mrdy;
    logic [31:0] r_pc;
    int          n_before;

    // Held-off downstream with 1-cycle memory: fill, stall, resume.
    vecs[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[3]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[4]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
    vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[8]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
    vecs[9]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    vecs[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    vecs[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

    // Reset values
    #2;
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_instr_data", instr_data, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_req_addr", imem_req_addr, RESET_PC);

    // Streaming with 1-cycle memory
    lat_min = 1; lat_max = 1;
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("boot_no_req", 32'(req_log.size()), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    check("stream_count", 32'(deliv_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (deliv_log.size() > i) check("stream_pc", deliv_log[i], 32'(i * 4));

    // Table: stall then release
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0, vecs[i].rdy, 1'b1);
      check("tbl_req_valid", 32'(s_req_valid), 32'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) check("tbl_req_addr", s_req_addr, vecs[i].exp_addr);
      check("tbl_instr_valid", 32'(s_instr_valid), 32'(vecs[i].exp_iv));
      if (vecs[i].exp_iv) begin
        check("tbl_instr_pc", s_instr_pc, vecs[i].exp_pc);
        check("tbl_instr_data", s_instr_data, vecs[i].exp_pc ^ SIG);
      end
    end

    // Redirect with two stale requests, 3-cycle memory
    lat_min = 3; lat_max = 3;
    do_reset();
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
    check("rd3_inflight", 32'(mem_q.size()), 32'd2);
    step(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("rd3_req_valid", 32'(s_req_valid), 32'h1);
    check("rd3_req_addr", s_req_addr, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      found = s_instr_valid;
    end
    check("rd3_found", 32'(found), 32'h1);
    check("rd3_first_pc", s_instr_pc, 32'h0000_0100);

    // Redirect coinciding with a response and a downstream pop
    lat_min = 2; lat_max = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      found = (mem_q.size() != 0) && (mem_q[0].due <= cyc) && (fifo_m.size() != 0);
      if (!found) step(1'b0, 32'h0, 1'b1, 1'b1);
    end
    check("rd4_setup", 32'(found), 32'h1);
    n_before = n_deliv;
    step(1'b1, 32'h0000_2000, 1'b1, 1'b1);
    check("rd4_pop_honoured", 32'(n_deliv - n_before), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("rd4_empty_after", 32'(s_instr_valid), 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      found = s_instr_valid;
    end
    check("rd4_found", 32'(found), 32'h1);
    check("rd4_first_pc", s_instr_pc, 32'h0000_2000);

    // Address wrap
    lat_min = 1; lat_max = 1;
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
    check("wrap_req_count", 32'(req_log.size() >= 3), 32'h1);
    if (req_log.size() >= 3) begin
      check("wrap_req0", req_log[0], 32'hFFFF_FFF8);
      check("wrap_req1", req_log[1], 32'hFFFF_FFFC);
      check("wrap_req2", req_log[2], 32'h0000_0000);
    end

    // Reset mid-stream with three buffered words
    do_reset();
    for (int i = 0; i < 20 && fifo_m.size() != 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    check("mrst_fill", 32'(fifo_m.size()), 32'd3);
    check("mrst_pre_valid", 32'(instr_valid), 32'h1);
    rst = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check("mrst_instr_valid", 32'(instr_valid), 32'h0);
    check("mrst_req_valid", 32'(imem_req_valid), 32'h0);
    check("mrst_instr_pc", instr_pc, 32'h0);
    check("mrst_instr_data", instr_data, 32'h0);
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("mrst_boot_req", 32'(s_req_valid), 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("mrst_restart_valid", 32'(s_req_valid), 32'h1);
    check("mrst_restart_addr", s_req_addr, RESET_PC);

    // Randomised traffic against the reference model
    lat_min = 1; lat_max = 4;
    do_reset();
    n_before = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      r_rdr  = ($urandom_range(99) < 3);
      r_pc   = $urandom;
      if ($urandom_range(3) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hF);
      r_rdy  = ($urandom_range(99) < 75);
      r_mrdy = ($urandom_range(99) < 80);
      step(r_rdr, r_pc, r_rdy, r_mrdy);
    end
    check("rand_progress", 32'((n_deliv - n_before) > 200), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
